// File: rtl/dalu_pkg.sv
// dalu_pkg: opcode constants and helpers shared by the issue stage and the dALU.
package dalu_pkg;

  localparam int DW = 8;

  localparam logic [3:0] OP_LDI = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;

  // Captured operand set for the execute slot (destination kept separate,
  // its width follows the register-file depth).
  typedef struct packed {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } x_ops_t;

  // Opcodes 7..15 have no ALU meaning.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_SHL);
  endfunction

endpackage

// File: rtl/dalu_regfile.sv
// dalu_regfile: NREGS x DW register file, two combinational read ports,
// one synchronous write port, asynchronous active-low clear.
module dalu_regfile #(
  parameter  int NREGS = 4,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd
);

  logic [DW-1:0] mem [NREGS];

  // Storage: cleared on reset, one write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = mem[ra1];
  assign rd2 = mem[ra2];

endmodule

// File: rtl/dalu_issue.sv
// dalu_issue: operand-issue and writeback stage in front of the 8-bit dALU.
// One execute slot drives the ALU; its result is presented on res_* and
// written back to the register file when the consumer accepts it.
// Build option DALU_ISSUE_BYPASS_EN: forward alu_out to a dependent
// instruction instead of stalling it for one cycle.
module dalu_issue
  import dalu_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [RA_W-1:0] in_rd,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [DW-1:0]   in_imm,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [3:0]      alu_op,
  input  logic [DW-1:0]   alu_out,
  input  logic            alu_zero,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [DW-1:0]   res_data,
  output logic [RA_W-1:0] res_rd,
  output logic            res_zero,
  output logic            zero_flag,
  output logic            err
);

  logic            x_valid;
  x_ops_t          x_ops;
  logic [RA_W-1:0] x_rd;

  logic [DW-1:0]   rf_rd1;
  logic [DW-1:0]   rf_rd2;
  logic            retire;
  logic            op_legal;
  logic            reads_rf;
  logic            hit1;
  logic            hit2;
  logic            hazard_stall;
  logic            accept;
  logic            load;
  logic [DW-1:0]   opnd_a;
  logic [DW-1:0]   opnd_b;
  x_ops_t          cap;

  dalu_regfile #(
    .NREGS (NREGS),
    .DW    (DW)
  ) u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (in_rs1),
    .ra2   (in_rs2),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (retire),
    .wa    (x_rd),
    .wd    (alu_out)
  );

  assign retire   = x_valid && res_ready;
  assign op_legal = is_legal_op(in_op);
  assign reads_rf = op_legal && (in_op != OP_LDI);

  // A source matches the slot that is being written back this very cycle,
  // so the register file still holds the stale value.
  assign hit1 = retire && reads_rf && (in_rs1 == x_rd);
  assign hit2 = retire && reads_rf && (in_rs2 == x_rd);

`ifdef DALU_ISSUE_BYPASS_EN
  assign hazard_stall = 1'b0;
  assign opnd_a       = hit1 ? alu_out : rf_rd1;
  assign opnd_b       = hit2 ? alu_out : rf_rd2;
`else
  // Hold the dependent instruction one cycle; X drains and the RF is current.
  assign hazard_stall = in_valid && (hit1 || hit2);
  assign opnd_a       = rf_rd1;
  assign opnd_b       = rf_rd2;
`endif

  assign in_ready = (!x_valid || res_ready) && !hazard_stall;
  assign accept   = in_valid && in_ready;
  assign load     = accept && op_legal;

  // Operand capture: LDI becomes imm | 0 so the ALU simply passes it through.
  always_comb begin
    cap.op = in_op;
    cap.a  = opnd_a;
    cap.b  = opnd_b;
    if (in_op == OP_LDI) begin
      cap.op = OP_OR;
      cap.a  = in_imm;
      cap.b  = '0;
    end
  end

  // Execute slot: refill on a legal accept, otherwise empty on retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_valid <= 1'b0;
      x_ops   <= '0;
      x_rd    <= '0;
    end else if (load) begin
      x_valid <= 1'b1;
      x_ops   <= cap;
      x_rd    <= in_rd;
    end else if (retire) begin
      x_valid <= 1'b0;
    end
  end

  // Status: zero flag of the last retired result, sticky illegal-op error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (retire) zero_flag <= alu_zero;
      if (accept && !op_legal) err <= 1'b1;
    end
  end

  // The ALU sees OR of zeros when idle so it never decodes a junk opcode.
  assign alu_a  = x_valid ? x_ops.a  : '0;
  assign alu_b  = x_valid ? x_ops.b  : '0;
  assign alu_op = x_valid ? x_ops.op : OP_OR;

  assign res_valid = x_valid;
  assign res_data  = alu_out;
  assign res_zero  = alu_zero;
  assign res_rd    = x_rd;

endmodule

// File: tb/tb_dalu_issue.sv
// tb_dalu_issue: directed bench with a behavioural dALU and a result scoreboard.
module tb_dalu_issue;
  import dalu_pkg::*;

  typedef struct {
    logic [1:0] rd;
    logic [7:0] data;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_op;
  logic       alu_zero;
  logic       res_valid, res_ready, res_zero, zero_flag, err;
  logic [7:0] res_data;
  logic [1:0] res_rd;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t q[$];
  logic [7:0] mdl [4];
  logic last_zero = 1'b0;
  `ifdef DALU_ISSUE_BYPASS_EN
  localparam int GAP = 1;
  `else
  localparam int GAP = 2;
  `endif

  dalu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_zero(res_zero), .zero_flag(zero_flag), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_ADD:  return a + b;
      OP_SHL:  return {a[6:0], 1'b0};
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural dALU.
  always_comb begin
    alu_out  = alu_ref(alu_op, alu_a, alu_b);
    alu_zero = (alu_out == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Result monitor: compare every retiring result with the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && res_valid && res_ready) begin
      if (q.size() == 0) begin
        check("unexpected_result", res_valid, 1'b0);
      end else begin
        e = q.pop_front();
        check("res_data", res_data, e.data);
        check("res_rd", res_rd, e.rd);
        check("res_zero", res_zero, e.zero);
        last_zero = e.zero;
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm, output int acc);
    int n;
    logic [7:0] v;
    exp_t e;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (op <= OP_SHL) begin
      v = (op == OP_LDI) ? imm : alu_ref(op, mdl[rs1], mdl[rs2]);
      mdl[rd] = v;
      e.rd = rd; e.data = v; e.zero = (v == 8'h00);
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int c0, c1, c2, t;
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_rd = 2'd0; in_rs1 = 2'd0;
    in_rs2 = 2'd0; in_imm = 8'h00; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_alu_op", alu_op, 4'd1);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_zero_flag", zero_flag, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk);

    // Register file reads zero after reset.
    issue(OP_OR, 2'd0, 2'd0, 2'd1, 8'h00, t);
    issue(OP_OR, 2'd1, 2'd2, 2'd3, 8'h00, t);
    drain();

    // LDI / LDI / ADD, then read r2 back through an OR.
    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h02, t);
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h03, t);
    issue(OP_ADD, 2'd2, 2'd0, 2'd1, 8'h00, t);
    drain();
    #1 check("add_zero_flag", zero_flag, 1'b0);
    @(negedge clk);
    issue(OP_OR, 2'd3, 2'd2, 2'd2, 8'h00, t);
    drain();

    // Dependent chain: throughput depends on forwarding.
    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h01, c0);
    issue(OP_SHL, 2'd0, 2'd0, 2'd0, 8'h00, c1);
    issue(OP_SHL, 2'd0, 2'd0, 2'd0, 8'h00, c2);
    check("chain_gap1", c1 - c0, GAP);
    check("chain_gap2", c2 - c1, GAP);
    drain();

    // Backpressure: result held, nothing accepted, then released.
    res_ready = 1'b0;
    issue(OP_LDI, 2'd3, 2'd0, 2'd0, 8'hAA, t);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_res_valid", res_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_res_data", res_data, 8'hAA);
      check("bp_res_rd", res_rd, 2'd3);
      @(negedge clk);
    end
    res_ready = 1'b1;
    drain();
    issue(OP_XOR, 2'd2, 2'd3, 2'd1, 8'h00, t);
    drain();

    // AND producing zero.
    issue(OP_LDI, 2'd0, 2'd0, 2'd0, 8'h02, t);
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h05, t);
    issue(OP_AND, 2'd3, 2'd0, 2'd1, 8'h00, t);
    drain();
    #1 check("and_zero_flag", zero_flag, 1'b1);
    check("model_zero_flag", zero_flag, last_zero);
    @(negedge clk);

    // Illegal opcode: accepted, flagged, nothing retires.
    issue(4'd9, 2'd0, 2'd0, 2'd0, 8'h00, t);
    #1;
    check("ill_err", err, 1'b1);
    check("ill_no_result", res_valid, 1'b0);
    @(negedge clk);
    issue(OP_OR, 2'd2, 2'd0, 2'd0, 8'h00, t);
    issue(OP_LDI, 2'd2, 2'd0, 2'd0, 8'h5A, t);
    issue(OP_NOT, 2'd1, 2'd2, 2'd0, 8'h00, t);
    drain();
    #1 check("ill_err_sticky", err, 1'b1);
    @(negedge clk);

    // Reset with an instruction stalled in X: it must not reach the RF.
    res_ready = 1'b0;
    issue(OP_LDI, 2'd1, 2'd0, 2'd0, 8'h77, t);
    #1;
    rst_n = 1'b0;
    q.delete();
    for (int i = 0; i < 4; i++) mdl[i] = 8'h00;
    #1;
    check("mid_rst_res_valid", res_valid, 1'b0);
    check("mid_rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    issue(OP_OR, 2'd2, 2'd1, 2'd1, 8'h00, t);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
